// File: rtl/encrypt_v2_second_sol.sv
// Iterative PRESENT-80 encryption engine: one round per clock behind a 4-phase req/ack handshake.
// Optional macro ENCRYPT_ZEROIZE_EN clears c on the DONE -> IDLE edge.
module encrypt_v2_second_sol #(
    parameter int N_K = 80,
    parameter int N_B = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req,
    output logic           ack,
    input  logic [N_K-1:0] k,
    input  logic [N_B-1:0] m,
    output logic [N_B-1:0] c
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]     state;
    logic [N_B-1:0] s;
    logic [N_K-1:0] key;
    logic [4:0]     rnd;

    logic [N_B-1:0] round_in;
    logic [N_B-1:0] sub;
    logic [N_B-1:0] perm;
    logic [N_K-1:0] key_rot;
    logic [N_K-1:0] key_next;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Round datapath: add round key, substitution layer, bit permutation, next round key.
    always_comb begin
        round_in = s ^ key[N_K-1 -: N_B];
        sub      = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            sub[6'(4*i) +: 4] = sbox(round_in[6'(4*i) +: 4]);
        end
        perm = '0;
        for (int unsigned j = 0; j < 63; j++) begin
            perm[6'((16*j) % 63)] = sub[6'(j)];
        end
        perm[63] = sub[63];

        key_rot           = {key[18:0], key[79:19]};
        key_next          = key_rot;
        key_next[79:76]   = sbox(key_rot[79:76]);
        key_next[19:15]   = key_rot[19:15] ^ rnd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            s     <= '0;
            key   <= '0;
            rnd   <= '0;
            c     <= '0;
            ack   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        s     <= m;
                        key   <= k;
                        rnd   <= 5'd1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s   <= perm;
                    key <= key_next;
                    if (rnd == 5'd31) begin
                        state <= ST_FIN;
                    end else begin
                        rnd <= rnd + 5'd1;
                    end
                end
                ST_FIN: begin
                    // Whitening with round key 32 straight into the output register.
                    c     <= s ^ key[N_K-1 -: N_B];
                    ack   <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!req) begin
                        ack   <= 1'b0;
                        state <= ST_IDLE;
`ifdef ENCRYPT_ZEROIZE_EN
                        c     <= '0;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_v2_second_sol.sv
// Directed-vector bench for encrypt_v2_second_sol: known-answer PRESENT-80 vectors, handshake timing, reset abort.
module tb_encrypt_v2_second_sol;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        ack;
    logic [79:0] k;
    logic [63:0] m;
    logic [63:0] c;

    int n_checks;
    int n_pass;

    encrypt_v2_second_sol dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ack   (ack),
        .k     (k),
        .m     (m),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected c after ack falls: cleared when zeroization is built in, otherwise held.
    function automatic logic [63:0] c_after_fall(input logic [63:0] ct);
`ifdef ENCRYPT_ZEROIZE_EN
        return 64'h0;
`else
        return ct;
`endif
    endfunction

    // One full operation. drop_at > 0 drops req after that round edge; scramble alters k/m mid-run.
    task automatic run_op(input string tag, input logic [79:0] kk, input logic [63:0] mm,
                          input logic [63:0] exp, input int drop_at, input bit scramble);
        logic early;
        @(negedge clk);
        k   = kk;
        m   = mm;
        req = 1'b1;
        @(posedge clk);
        early = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            @(posedge clk);
            #1;
            if (ack !== 1'b0) early = 1'b1;
            if (i == drop_at) req = 1'b0;
            if (scramble && i == 3) begin
                k = ~kk ^ 80'h123456789ABCDEF01234;
                m = ~mm ^ 64'hDEADBEEFCAFEF00D;
            end
        end
        check({tag, "_no_early_ack"}, {63'd0, early}, 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_ack_at_e32"}, {63'd0, ack}, 64'd1);
        check({tag, "_c"}, c, exp);
        if (drop_at > 0) begin
            @(posedge clk);
            #1;
            check({tag, "_ack_fall_e33"}, {63'd0, ack}, 64'd0);
        end else begin
            @(posedge clk);
            #1;
            check({tag, "_ack_hold"}, {63'd0, ack}, 64'd1);
            check({tag, "_c_hold"}, c, exp);
            @(negedge clk);
            req = 1'b0;
            @(posedge clk);
            #1;
            check({tag, "_ack_fall"}, {63'd0, ack}, 64'd0);
        end
        check({tag, "_c_idle"}, c, c_after_fall(exp));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        req      = 1'b0;
        k        = '0;
        m        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {63'd0, ack}, 64'd0);
        check("reset_c", c, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ack_no_req", {63'd0, ack}, 64'd0);

        run_op("v1", 80'h0, 64'h0, 64'h5579C1387B228445, 0, 1'b0);
        run_op("v2", {80{1'b1}}, 64'h0, 64'hE72C46C0F5945049, 0, 1'b0);
        run_op("v3", 80'h0, {64{1'b1}}, 64'hA112FFC72F68417B, 0, 1'b1);
        run_op("v4", {80{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2, 5, 1'b0);

        // Abort an operation at round 10 with an asynchronous reset.
        @(negedge clk);
        k   = {80{1'b1}};
        m   = 64'h0;
        req = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ack", {63'd0, ack}, 64'd0);
        check("abort_c", c, 64'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_late_ack", {63'd0, ack}, 64'd0);

        run_op("v1_rerun", 80'h0, 64'h0, 64'h5579C1387B228445, 0, 1'b0);
        run_op("b2b_v3", 80'h0, {64{1'b1}}, 64'hA112FFC72F68417B, 0, 1'b0);
        run_op("b2b_v2", {80{1'b1}}, 64'h0, 64'hE72C46C0F5945049, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
